// File: rtl/div_unit_rv64m_pkg.sv
// Shared types and helpers for the RV64M divide unit.
// Operation encodings, FSM states and sign/extension helpers.
package div_unit_rv64m_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_RESP,
    S_DRAIN
  } div_state_e;

  function automatic logic [XLEN-1:0] sext32(
    input logic [31:0] x
  );
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] neg_if(
    input logic [XLEN-1:0] x,
    input logic            c
  );
    return c ? (~x + 1'b1) : x;
  endfunction

  // Pick quotient or remainder and apply the W-form sign extension
  function automatic logic [XLEN-1:0] div_final(
    input logic [1:0]      op,
    input logic            word,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r
  );
    logic [XLEN-1:0] sel;
    sel = op[1] ? r : q;
    return word ? sext32(sel[31:0]) : sel;
  endfunction

endpackage

// File: rtl/div_unit_rv64m_if.sv
// Execute-stage request/response bundle for the divide unit.
// master = issuing stage, slave = divide unit.
interface div_unit_rv64m_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_word;
  logic [63:0]      in_rs1;
  logic [63:0]      in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_word,
    output in_rs1, in_rs2, in_tag,
    output out_ready,
    input  in_ready, out_valid,
    input  out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_word,
    input  in_rs1, in_rs2, in_tag,
    input  out_ready,
    output in_ready, out_valid,
    output out_result, out_tag
  );
endinterface

// File: rtl/MulCyc_Div.sv
// Unsigned restoring divider, one quotient bit per clock.
// ready drops after start, rises one cycle after the last iteration.
module MulCyc_Div #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  q_r;
  logic [W-1:0]  r_r;
  logic [W-1:0]  d_r;
  logic [CW-1:0] cnt;
  logic          rdy;

  logic [W:0]   r_sh;
  logic [W:0]   diff;
  logic         ge;
  logic [W-1:0] r_nx;
  logic [W-1:0] q_nx;

  // Partial remainder stays below the divisor, so W+1 bits suffice
  always_comb begin
    r_sh = {r_r, q_r[W-1]};
    diff = r_sh - {1'b0, d_r};
    ge   = ~diff[W];
    r_nx = ge ? diff[W-1:0] : r_sh[W-1:0];
    q_nx = {q_r[W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rdy <= 1'b1;
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
      cnt <= '0;
    end else if (rdy) begin
      if (start) begin
        rdy <= 1'b0;
        q_r <= dividend;
        r_r <= '0;
        d_r <= divisor;
        cnt <= '0;
      end
    end else if (cnt == CW'(W)) begin
      rdy <= 1'b1;
    end else begin
      q_r <= q_nx;
      r_r <= r_nx;
      cnt <= cnt + 1'b1;
    end
  end

  assign ready     = rdy;
  assign quotient  = q_r;
  assign remainder = r_r;

endmodule

// File: rtl/div_unit_rv64m.sv
// RV64M divide issue/retire stage around MulCyc_Div.
// Handles signs, W forms and div-by-zero/overflow locally.
module div_unit_rv64m
  import div_unit_rv64m_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  div_unit_rv64m_if.slave  bus
);

  div_state_e       state;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             core_start;
  logic             armed;
  logic [1:0]       op_r;
  logic             word_r;
  logic             neg_q;
  logic             neg_r;
  logic [XLEN-1:0]  a_r;
  logic [XLEN-1:0]  b_r;

  logic            core_ready;
  logic [XLEN-1:0] core_q;
  logic [XLEN-1:0] core_r;

  logic            accept;
  logic            signed_op;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] min_val;
  logic            dbz;
  logic            ovf;
  logic [XLEN-1:0] sp_res;
  logic [XLEN-1:0] post_res;

  assign accept = bus.in_valid && (state == S_IDLE) && !flush;

  always_comb begin
    signed_op = ~bus.in_op[0];
    a_ext = bus.in_rs1;
    b_ext = bus.in_rs2;
    if (bus.in_word) begin
      a_ext = signed_op ? sext32(bus.in_rs1[31:0])
                        : {32'b0, bus.in_rs1[31:0]};
      b_ext = signed_op ? sext32(bus.in_rs2[31:0])
                        : {32'b0, bus.in_rs2[31:0]};
    end
    sa      = signed_op & a_ext[XLEN-1];
    sb      = signed_op & b_ext[XLEN-1];
    a_mag   = neg_if(a_ext, sa);
    b_mag   = neg_if(b_ext, sb);
    min_val = bus.in_word ? 64'hFFFF_FFFF_8000_0000
                          : 64'h8000_0000_0000_0000;
    dbz     = (b_ext == '0);
    ovf     = signed_op && (a_ext == min_val) && (&b_ext);
    sp_res  = dbz ? div_final(bus.in_op, bus.in_word, '1, a_ext)
                  : div_final(bus.in_op, bus.in_word, a_ext, '0);
    post_res = div_final(op_r, word_r,
                         neg_if(core_q, neg_q),
                         neg_if(core_r, neg_r));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      core_start   <= 1'b0;
      armed        <= 1'b0;
      op_r         <= '0;
      word_r       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_r      <= bus.in_op;
            word_r    <= bus.in_word;
            neg_q     <= sa ^ sb;
            neg_r     <= sa;
            out_tag_q <= bus.in_tag;
            if (dbz || ovf) begin
              out_result_q <= sp_res;
              out_valid_q  <= 1'b1;
              state        <= S_RESP;
            end else begin
              a_r        <= a_mag;
              b_r        <= b_mag;
              core_start <= 1'b1;
              armed      <= 1'b0;
              state      <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          core_start <= 1'b0;
          state      <= flush ? S_DRAIN : S_BUSY;
        end
        S_BUSY: begin
          if (!core_ready) armed <= 1'b1;
          // Core finishing on the flush cycle needs no drain
          if (armed && core_ready) begin
            if (flush) begin
              state <= S_IDLE;
            end else begin
              out_result_q <= post_res;
              out_valid_q  <= 1'b1;
              state        <= S_RESP;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_RESP: begin
          if (flush || bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (!core_ready) armed <= 1'b1;
          if (armed && core_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  MulCyc_Div #(
    .W (XLEN)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .start     (core_start),
    .dividend  (a_r),
    .divisor   (b_r),
    .ready     (core_ready),
    .quotient  (core_q),
    .remainder (core_r)
  );

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_div_unit_rv64m.sv
// Directed self-checking bench for div_unit_rv64m.
// Hand-computed vectors, immediate assertions.
module tb_div_unit_rv64m;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   vectors = 0;
  int   miscompares = 0;
  int   starts = 0;

  div_unit_rv64m_if #(.TAG_W(5)) bus ();

  div_unit_rv64m #(
    .TAG_W (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.core_start) starts++;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic word,
                       input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [4:0] tag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_word  = word;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_tag   = tag;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input string name,
                     input logic [1:0] op, input logic word,
                     input logic [63:0] rs1, input logic [63:0] rs2,
                     input logic [4:0] tag, input logic [63:0] exp,
                     input int exp_lat, input int hold);
    int cyc;
    int s0;
    s0 = starts;
    issue(op, word, rs1, rs2, tag);
    check({name, " in_ready"}, 64'(bus.in_ready), 64'd0);
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " out_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, " latency"}, 64'(cyc), 64'(exp_lat));
    check({name, " result"}, bus.out_result, exp);
    check({name, " tag"}, 64'(bus.out_tag), 64'(tag));
    check({name, " starts"}, 64'(starts - s0),
          (exp_lat == 1) ? 64'd0 : 64'd1);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    if (hold > 0) begin
      check({name, " hold valid"}, 64'(bus.out_valid), 64'd1);
      check({name, " hold result"}, bus.out_result, exp);
      check({name, " hold tag"}, 64'(bus.out_tag), 64'(tag));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, " retire"}, 64'(bus.out_valid), 64'd0);
    check({name, " idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int  cyc;
    logic seen;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_word   = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst out_result", bus.out_result, 64'd0);
    check("rst out_tag", 64'(bus.out_tag), 64'd0);
    check("rst core_start", 64'(dut.core_start), 64'd0);
    rst_n = 1'b1;

    run("div -7/2", 2'b00, 1'b0, -64'sd7, 64'd2, 5'd3,
        64'hFFFF_FFFF_FFFF_FFFD, 68, 0);
    run("rem -7/2", 2'b10, 1'b0, -64'sd7, 64'd2, 5'd4,
        64'hFFFF_FFFF_FFFF_FFFF, 68, 0);
    run("divu 100/7", 2'b01, 1'b0, 64'd100, 64'd7, 5'd17,
        64'd14, 68, 3);
    run("remu 100/7", 2'b11, 1'b0, 64'd100, 64'd7, 5'd18,
        64'd2, 68, 0);
    run("div 42/0", 2'b00, 1'b0, 64'd42, 64'd0, 5'd5,
        64'hFFFF_FFFF_FFFF_FFFF, 1, 2);
    run("rem 42/0", 2'b10, 1'b0, 64'd42, 64'd0, 5'd6,
        64'd42, 1, 0);
    run("remu 42/0", 2'b11, 1'b0, 64'd42, 64'd0, 5'd7,
        64'd42, 1, 0);
    run("div min/-1", 2'b00, 1'b0, 64'h8000_0000_0000_0000, '1,
        5'd8, 64'h8000_0000_0000_0000, 1, 0);
    run("rem min/-1", 2'b10, 1'b0, 64'h8000_0000_0000_0000, '1,
        5'd9, 64'd0, 1, 0);
    run("divw min/-1", 2'b00, 1'b1, 64'h0000_0000_8000_0000, '1,
        5'd10, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run("divuw ffffffff/1", 2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF,
        64'd1, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 68, 0);
    run("remw -9/4", 2'b10, 1'b1, -64'sd9, 64'd4, 5'd12,
        64'hFFFF_FFFF_FFFF_FFFF, 68, 0);

    // Flush while the core is iterating
    issue(2'b01, 1'b0, 64'd100, 64'd7, 5'd20);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy in_ready", 64'(bus.in_ready), 64'd0);
    seen = 1'b0;
    cyc = 0;
    while (!bus.in_ready && cyc < 200) begin
      seen = seen | bus.out_valid;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("flush busy no valid", 64'(seen | bus.out_valid), 64'd0);
    check("flush busy drained", 64'(bus.in_ready), 64'd1);
    check("flush busy drain long", 64'(cyc > 40), 64'd1);
    run("after flush divu", 2'b01, 1'b0, 64'd100, 64'd7, 5'd21,
        64'd14, 68, 0);

    // Flush in IDLE blocks the accept
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_rs1   = 64'd9;
    bus.in_rs2   = 64'd0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    check("flush idle in_ready", 64'(bus.in_ready), 64'd1);
    check("flush idle out_valid", 64'(bus.out_valid), 64'd0);

    // Flush in RESP beats out_ready
    issue(2'b00, 1'b0, 64'd5, 64'd0, 5'd22);
    check("resp valid", 64'(bus.out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush resp out_valid", 64'(bus.out_valid), 64'd0);
    check("flush resp in_ready", 64'(bus.in_ready), 64'd1);

    // Reset mid-operation
    issue(2'b00, 1'b0, 64'd1000, 64'd3, 5'd23);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst core ready", 64'(dut.core_ready), 64'd1);
    run("after reset div", 2'b00, 1'b0, 64'd1000, -64'sd3, 5'd24,
        -64'sd333, 68, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
